// File: rtl/lint2apb_master_if.sv
// Bus bundle for lint2apb_master: core-side LINT data port and APB master port.
// The master modport is the bridge's view; slave is the core/peripheral side.
interface lint2apb_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic [ADDR_W-1:0]     data_addr_i;
    logic                  data_we_i;
    logic [DATA_W/8-1:0]   data_be_i;
    logic [DATA_W-1:0]     data_wdata_i;
    logic                  data_rvalid_o;
    logic [DATA_W-1:0]     data_rdata_o;
    logic                  data_err_o;
    logic [ADDR_W-1:0]     paddr_o;
    logic [DATA_W-1:0]     pwdata_o;
    logic                  pwrite_o;
    logic [DATA_W/8-1:0]   pstrb_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pready_i;
    logic [DATA_W-1:0]     prdata_i;
    logic                  pslverr_i;

    modport master (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output paddr_o, pwdata_o, pwrite_o, pstrb_o, psel_o, penable_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  paddr_o, pwdata_o, pwrite_o, pstrb_o, psel_o, penable_o,
        output pready_i, prdata_i, pslverr_i
    );
endinterface

// File: rtl/lint2apb_master.sv
// Single-outstanding LINT-to-APB bridge with an ACCESS-phase watchdog.
// timeout_o is registered and pulses in the RESP cycle of an aborted transfer.
module lint2apb_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    lint2apb_master_if.master bus,
    output logic              timeout_o
);
    localparam int unsigned BE_W = APB_DATA_WIDTH / 8;
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [BE_W-1:0]           pstrb_q, pstrb_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      timeout_q, timeout_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic                      grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = 1'b0;
        wd_d      = wd_q;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                grant = bus.data_req_i;
                if (bus.data_req_i) begin
                    paddr_d  = {bus.data_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                    pwrite_d = bus.data_we_i;
                    pwdata_d = bus.data_wdata_i;
                    pstrb_d  = bus.data_we_i ? bus.data_be_i : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready_i) begin
                    rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    err_d   = bus.pslverr_i;
                    state_d = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                wd_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is masked during reset so nothing looks accepted while held in reset.
    assign bus.data_gnt_o    = grant & rst_ni;
    assign bus.data_rvalid_o = (state_q == RESP);
    assign bus.data_rdata_o  = rdata_q;
    assign bus.data_err_o    = err_q;
    assign bus.paddr_o       = paddr_q;
    assign bus.pwdata_o      = pwdata_q;
    assign bus.pwrite_o      = pwrite_q;
    assign bus.pstrb_o       = pstrb_q;
    assign bus.psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o     = (state_q == ACCESS);
    assign timeout_o         = timeout_q;
endmodule

// File: doc/lint2apb_master.md
Name: lint2apb_master

Overview:
- Single-outstanding bridge from the core-side LINT data port (req/gnt/rvalid) to an APB master port.
- It is the initiator end of the peripheral APB bus. Its APB outputs drive the slave port of the peripheral bus node, which decodes addresses to UART, GPIO, SPI, timer and the other peripherals.
- Sequences the APB SETUP/ACCESS phases, waits on PREADY, returns read data and error status to the core.
- A programmable watchdog aborts stalled transfers.

Parameters:
- APB_ADDR_WIDTH, 32, width of data_addr_i and paddr_o.
- APB_DATA_WIDTH, 32, width of all data buses (fixed at 32 in this release). Byte-enable width is APB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles waiting for pready_i before abort. 0 disables the watchdog.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- data_req_i  input  1  core request
- data_gnt_o  output  1  request accepted
- data_addr_i  input  APB_ADDR_WIDTH  byte address
- data_we_i  input  1  1=write, 0=read
- data_be_i  input  APB_DATA_WIDTH/8  byte enables
- data_wdata_i  input  APB_DATA_WIDTH  write data
- data_rvalid_o  output  1  response valid (read and write)
- data_rdata_o  output  APB_DATA_WIDTH  read data
- data_err_o  output  1  response error, valid with data_rvalid_o
- paddr_o  output  APB_ADDR_WIDTH  APB address
- pwdata_o  output  APB_DATA_WIDTH  APB write data
- pwrite_o  output  1  APB direction
- pstrb_o  output  APB_DATA_WIDTH/8  APB write strobes
- psel_o  output  1  APB select
- penable_o  output  1  APB enable
- pready_i  input  1  APB ready
- prdata_i  input  APB_DATA_WIDTH  APB read data
- pslverr_i  input  1  APB slave error
- timeout_o  output  1  one-cycle pulse when the watchdog aborts a transfer

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; watchdog counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - data_gnt_o = data_req_i (combinational, IDLE only). Grant is 0 in every other state.
  - On req&gnt, register the transfer:
    - paddr_o = {data_addr_i[MSB:2], 2'b00}
    - pwrite_o = data_we_i
    - pwdata_o = data_wdata_i
    - pstrb_o = data_we_i ? data_be_i : 0
  - Next state SETUP.
- SETUP: psel_o=1, penable_o=0. Next state always ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - paddr/pwrite/pwdata/pstrb are held stable from SETUP through the end of ACCESS.
  - pready_i=1: capture data_rdata_o = pwrite_o ? 0 : prdata_i and data_err_o = pslverr_i. Next state RESP.
  - pready_i=0: increment the watchdog.
  - Watchdog abort: if TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES-1 with pready_i=0, set data_rdata_o=0, data_err_o=1, pulse timeout_o for 1 cycle. Next state RESP. psel/penable drop on the next edge.
- RESP:
  - psel_o=0, penable_o=0.
  - data_rvalid_o=1 for exactly this cycle; data_rdata_o/data_err_o valid.
  - Next state IDLE. Watchdog is cleared.
- Outside RESP: data_rvalid_o=0. data_rdata_o and data_err_o hold their last values.
- Minimum latency: grant in cycle N, SETUP N+1, ACCESS N+2 (zero-wait), rvalid N+3. Peak throughput is one transfer per 4 cycles.
- Each APB wait state adds one cycle to the latency.
- A request presented in SETUP/ACCESS/RESP is not granted. It is granted on the first IDLE cycle.
- pslverr_i is sampled only when pready_i=1 in ACCESS. It is ignored at all other times.
- pready_i asserted during SETUP is ignored.
- Reset mid-transfer: asynchronous return to IDLE with all outputs 0. No response is generated for the aborted transfer.
- Unaligned addresses: low 2 bits are dropped. No error is raised.

Test Plan:
- Zero-wait read: req addr 0x1A10_1004, we=0; slave pready=1, prdata=0xCAFE_F00D -> gnt cycle 0; psel cycle 1; psel&penable cycle 2; rvalid cycle 3 with rdata=0xCAFE_F00D, err=0.
- Wait-state write: we=1, be=4'b0011, wdata=0x1234_5678, addr 0x1A10_0008; pready low 3 cycles -> paddr/pwdata/pstrb=0x3 stable across 4 ACCESS cycles; rvalid 1 cycle after pready, rdata=0, err=0.
- Slave error: read with pready=1, pslverr=1 -> rvalid with err=1. A following read with pslverr=0 -> err=0.
- Watchdog: TIMEOUT_CYCLES=4, pready stuck 0 -> penable high exactly 4 cycles; timeout_o pulses once; rvalid with err=1, rdata=0. FSM returns to IDLE and the next request is granted.
- Back-to-back plus reset: req held high for 2 transfers -> second gnt exactly 1 cycle after the first rvalid. Asserting rst_ni=0 during ACCESS -> psel/penable/rvalid go 0 immediately; no rvalid after reset release.
